// File: rtl/fdc_pkg.sv
// Shared types and constants for the FDC <-> host DMA byte-transfer engine.
package fdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_READ  = 1'b1;  // FIFO -> host
  localparam logic DIR_WRITE = 1'b0;  // host -> FIFO

endpackage

// File: rtl/fdc_dma_watchdog.sv
// Req-without-ack watchdog: counts enabled cycles, saturates at all-ones,
// and reports expiry while the count sits there.
module fdc_dma_watchdog #(
  parameter int TIMEOUT_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  assign expired = &cnt_q;

  // Next count: clear wins, otherwise count up until saturated.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fdc_dma_xfer.sv
// Byte-transfer engine between the FDC data FIFO and the host 8237 DMA channel.
// Read moves FIFO bytes to the host on DACK; write pushes host bytes into the FIFO.
module fdc_dma_xfer
  import fdc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LEN_W     = 16,
  parameter int TIMEOUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             fifo_rdreq,
  output logic             fifo_wrreq,
  output logic [WIDTH-1:0] fifo_data,
  output logic             dma_req,
  input  logic             dma_ack,
  input  logic             dma_tc,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining,
  output logic             err_timeout,
  output logic             err_spur
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             dma_req_q, dma_req_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_spur_q, err_spur_d;
  logic             accepted;
  logic             avail;
  logic             wd_expired;

  // The watchdog only runs while DRQ is up and unanswered.
  fdc_dma_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (dma_req_q && !dma_ack),
    .clr     (!dma_req_q || dma_ack),
    .expired (wd_expired)
  );

  // Abort and timeout both pre-empt an ack arriving in the same cycle.
  assign accepted = dma_ack && dma_req_q && (state_q == XFER) && !abort && !wd_expired;

  // Next-state, counters, error flags and the registered DRQ.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    remaining_d   = remaining_q;
    err_timeout_d = err_timeout_q;
    err_spur_d    = err_spur_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dir_d         = dir;
          remaining_d   = xfer_len;
          err_timeout_d = 1'b0;
          err_spur_d    = 1'b0;
          state_d       = (xfer_len == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wd_expired) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else if (accepted) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1) || dma_tc) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An ack without a pending request is flagged even if start clears the flags this cycle.
    if (dma_ack && !dma_req_q) err_spur_d = 1'b1;

    // Space/data check uses the direction that will be in force next cycle.
    avail     = (dir_d == DIR_READ) ? !fifo_empty : !fifo_full;
    // Dropping DRQ after every accepted ack leaves one cycle for the FIFO flags to settle.
    dma_req_d = (state_d == XFER) && avail && !accepted;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dir_q         <= DIR_WRITE;
      remaining_q   <= '0;
      dma_req_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_spur_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      remaining_q   <= remaining_d;
      dma_req_q     <= dma_req_d;
      err_timeout_q <= err_timeout_d;
      err_spur_q    <= err_spur_d;
    end
  end

  assign fifo_rdreq  = accepted && (dir_q == DIR_READ);
  assign fifo_wrreq  = accepted && (dir_q == DIR_WRITE);
  assign fifo_data   = dma_wdata;
  assign dma_rdata   = (busy && dir_q == DIR_READ) ? fifo_q : '0;
  assign dma_req     = dma_req_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign remaining   = remaining_q;
  assign err_timeout = err_timeout_q;
  assign err_spur    = err_spur_q;

endmodule

// File: tb/tb_fdc_dma_xfer.sv
// Scoreboard bench for fdc_dma_xfer: a queue-based show-ahead FIFO, a host that
// acks DRQ after a fixed delay, expected bytes/done records pushed at stimulus
// time and popped by a negedge monitor.
module tb_fdc_dma_xfer;

  localparam int WIDTH     = 8;
  localparam int LEN_W     = 16;
  localparam int TIMEOUT_W = 12;
  localparam int DEPTH     = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] xfer_len = '0;
  logic [WIDTH-1:0] fifo_q = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_full = 1'b0;
  logic             fifo_rdreq, fifo_wrreq;
  logic [WIDTH-1:0] fifo_data;
  logic             dma_req;
  logic             dma_ack = 1'b0;
  logic             dma_tc = 1'b0;
  logic [WIDTH-1:0] dma_wdata = '0;
  logic [WIDTH-1:0] dma_rdata;
  logic             busy, done;
  logic [LEN_W-1:0] remaining;
  logic             err_timeout, err_spur;

  fdc_dma_xfer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .xfer_len(xfer_len),
    .abort(abort), .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_rdreq(fifo_rdreq), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_tc(dma_tc), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .busy(busy), .done(done), .remaining(remaining),
    .err_timeout(err_timeout), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: FIFO contents, expected bytes in transfer order, expected remaining at each done.
  logic [WIDTH-1:0] fifo_m[$];
  logic [WIDTH-1:0] preload_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [LEN_W-1:0] exp_done_q[$];
  logic [WIDTH-1:0] wq[$];
  int flush_req = 0, flush_seen = 0;
  int pops = 0, pushes = 0, done_cnt = 0;

  // Host controls (written only by the main sequence).
  logic host_en = 1'b0;
  logic cur_dir = 1'b1;
  int   ack_delay = 2;
  int   tc_at = 0;
  int   force_ack_req = 0;
  // Host-private state.
  int   host_req_cnt = 0, host_ack_n = 0, host_force_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Host DMA channel: acks DRQ after ack_delay cycles, optionally raises TC, or forces a bare ack.
  initial begin
    forever begin
      @(posedge clk); #1;
      dma_ack = 1'b0;
      dma_tc  = 1'b0;
      if (!busy) host_ack_n = 0;
      if (force_ack_req != host_force_seen) begin
        host_force_seen = force_ack_req;
        dma_ack = 1'b1;
      end else if (host_en && dma_req) begin
        host_req_cnt++;
        if (host_req_cnt >= ack_delay) begin
          host_req_cnt = 0;
          host_ack_n++;
          dma_ack = 1'b1;
          dma_tc  = (host_ack_n == tc_at);
          if (!cur_dir && wq.size() > 0) dma_wdata = wq.pop_front();
        end
      end else begin
        host_req_cnt = 0;
      end
    end
  end

  // Monitor + FIFO model: compares at each accepted ack and done pulse, then updates the FIFO.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dma_ack && dma_req && busy && !abort) begin
        check("ack_fifo_strobe", cur_dir ? fifo_rdreq : fifo_wrreq, 1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", cur_dir ? dma_rdata : fifo_data);
        end else begin
          check("byte", cur_dir ? dma_rdata : fifo_data, exp_q.pop_front());
        end
      end else if (dma_ack) begin
        check("no_fifo_access", {fifo_rdreq, fifo_wrreq}, 0);
      end
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got remaining=%0d expected no done", remaining);
        end else begin
          check("done_remaining", remaining, exp_done_q.pop_front());
        end
      end
      if (fifo_rdreq) begin
        if (fifo_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_empty: got pop expected none");
        end else begin
          void'(fifo_m.pop_front());
        end
        pops++;
      end
      if (fifo_wrreq) begin
        if (fifo_m.size() >= DEPTH) begin
          checks++; errors++;
          $display("FAIL push_full: got push expected none");
        end else begin
          fifo_m.push_back(fifo_data);
        end
        pushes++;
      end
    end
    if (flush_req != flush_seen) begin
      flush_seen = flush_req;
      fifo_m.delete();
    end
    while (preload_q.size() > 0) fifo_m.push_back(preload_q.pop_front());
    fifo_empty = (fifo_m.size() == 0);
    fifo_full  = (fifo_m.size() >= DEPTH);
    fifo_q     = fifo_empty ? '0 : fifo_m[0];
  end

  task automatic do_start(input logic d, input int len);
    @(posedge clk); #1;
    cur_dir  = d;
    dir      = d;
    xfer_len = LEN_W'(len);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clk);
    check(name, done_cnt - d0, 1);
    @(posedge clk); #1;
  endtask

  task automatic flush();
    flush_req++;
    @(negedge clk);
  endtask

  initial begin
    int p0, d0, hi;
    logic [WIDTH-1:0] b;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req", dma_req, 0);
    check("rst_done", done, 0);
    check("rst_remaining", remaining, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_spur", err_spur, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: read 4 bytes A1..A4, ack 2 cycles after each req.
    for (int i = 1; i <= 4; i++) begin
      preload_q.push_back(8'(8'hA0 + i));
      exp_q.push_back(8'(8'hA0 + i));
    end
    exp_done_q.push_back('0);
    @(negedge clk);
    host_en = 1'b1; ack_delay = 2; tc_at = 0;
    p0 = pops;
    do_start(1'b1, 4);
    wait_done(200, "t1_done");
    check("t1_pops", pops - p0, 4);
    check("t1_remaining", remaining, 0);
    check("t1_errs", {err_timeout, err_spur}, 0);

    // 2: write 0x11, 0x22, 0x33.
    p0 = pushes;
    for (int i = 1; i <= 3; i++) begin
      wq.push_back(8'(8'h11 * i));
      exp_q.push_back(8'(8'h11 * i));
    end
    exp_done_q.push_back('0);
    do_start(1'b0, 3);
    wait_done(200, "t2_done");
    check("t2_pushes", pushes - p0, 3);
    check("t2_usedw", fifo_m.size(), 3);
    flush();

    // 3: read 8, FIFO runs dry after 2 bytes, refilled later.
    p0 = pops;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      preload_q.push_back(b); exp_q.push_back(b);
    end
    exp_done_q.push_back('0);
    @(negedge clk);
    ack_delay = 1 + int'($urandom_range(0, 2));
    do_start(1'b1, 8);
    for (int c = 0; c < 200 && pops - p0 < 2; c++) @(negedge clk);
    check("t3_first_two", pops - p0, 2);
    repeat (6) @(negedge clk);
    check("t3_req_low_empty", dma_req, 0);
    check("t3_still_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      preload_q.push_back(b); exp_q.push_back(b);
    end
    wait_done(400, "t3_done");
    check("t3_pops", pops - p0, 8);
    check("t3_errs", {err_timeout, err_spur}, 0);

    // 4: read 10, TC on the 3rd ack -> short transfer with 7 left.
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      preload_q.push_back(b);
      if (i < 3) exp_q.push_back(b);
    end
    exp_done_q.push_back(LEN_W'(7));
    @(negedge clk);
    ack_delay = 2; tc_at = 3;
    do_start(1'b1, 10);
    wait_done(200, "t4_done");
    tc_at = 0;
    check("t4_pops", pops - p0, 3);
    check("t4_remaining", remaining, 7);
    flush();

    // 5: req never acked -> timeout, then a zero-length start clears the flag.
    host_en = 1'b0;
    preload_q.push_back(8'h5A);
    @(negedge clk);
    d0 = done_cnt; hi = 0;
    do_start(1'b1, 1);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (dma_req) hi++;
      if (!busy) break;
    end
    // 4095 counted req cycles reach all-ones; the expiry cycle itself is the 4096th req cycle.
    check("t5_req_cycles", hi, 4096);
    check("t5_err_timeout", err_timeout, 1);
    check("t5_req", dma_req, 0);
    check("t5_busy", busy, 0);
    check("t5_no_done", done_cnt - d0, 0);
    flush();
    exp_done_q.push_back('0);
    do_start(1'b0, 0);
    wait_done(20, "t5_len0_done");
    check("t5_cleared", err_timeout, 0);

    // 6a: abort with a simultaneous ack -> no pop, idle next cycle, remaining held.
    for (int i = 0; i < 4; i++) preload_q.push_back(8'($urandom_range(0, 255)));
    @(negedge clk);
    p0 = pops; d0 = done_cnt;
    do_start(1'b1, 4);
    for (int c = 0; c < 20 && !dma_req; c++) @(negedge clk);
    check("t6_req_up", dma_req, 1);
    @(posedge clk);
    force_ack_req++;
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_req", dma_req, 0);
    check("t6_remaining", remaining, 4);
    check("t6_pops", pops - p0, 0);
    check("t6_errs", {err_timeout, err_spur}, 0);

    // 6b: bare ack while idle -> spurious flag, no FIFO access.
    @(posedge clk);
    force_ack_req++;
    @(posedge clk); #2;
    check("t6_err_spur", err_spur, 1);
    check("t6_spur_pops", pops - p0, 0);
    check("t6_no_done", done_cnt - d0, 0);
    flush();

    check("sb_bytes_drained", exp_q.size(), 0);
    check("sb_done_drained", exp_done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
